// File: rtl/result_writeback.sv
// -----------------------------------------------------------------------------
// result_writeback
//
// Write-back engine for the NPU datapath. On start it snapshots the PE
// accumulator results and latches base_addr, stride and relu_en. It then
// writes the results to memory as WORD_W-bit words, LANES results per word,
// through a registered req/ack write port. main_control triggers it at the
// end of each layer.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          asynchronous, active-low reset
//   start        one-cycle request to begin write-back (sampled only in IDLE)
//   base_addr    address of word 0 (sampled with start)
//   stride       address increment between words (sampled with start)
//   relu_en      clamp negative results to zero (sampled with start)
//   results      flattened PE results; result i at [i*RES_W +: RES_W]
//   mem_wr_req   write request (registered)
//   mem_wr_addr  write address, stable while the request is pending
//   mem_wr_data  write data, stable while the request is pending
//   mem_wr_ack   memory accepts the write when req and ack are both 1
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last word has been accepted
//
// Optional build macro
//   WB_SKIP_ZERO_EN  when defined, a word whose post-ReLU lanes are all zero
//                    is not written. Its index and address slot are still
//                    consumed, so it costs a single PACK cycle.
// -----------------------------------------------------------------------------
module result_writeback #(
    parameter int NUM_RESULTS = 32,
    parameter int RES_W       = 16,
    parameter int WORD_W      = 64,
    parameter int ADDR_W      = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             stride,
    input  logic                          relu_en,
    input  logic [NUM_RESULTS*RES_W-1:0]  results,
    output logic                          mem_wr_req,
    output logic [ADDR_W-1:0]             mem_wr_addr,
    output logic [WORD_W-1:0]             mem_wr_data,
    input  logic                          mem_wr_ack,
    output logic                          busy,
    output logic                          done
);

    localparam int LANES     = WORD_W / RES_W;
    localparam int NUM_WORDS = NUM_RESULTS / LANES;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                                      state_q, state_d;
    // Snapshot organised as [word][lane][bit]; this layout matches the flat
    // results bus bit for bit, so the capture is a plain assignment.
    logic [NUM_WORDS-1:0][LANES-1:0][RES_W-1:0]  snap_q, snap_d;
    logic [IDX_W-1:0]                            idx_q, idx_d;
    logic [ADDR_W-1:0]                           base_q, base_d;
    logic [ADDR_W-1:0]                           stride_q, stride_d;
    logic                                        relu_q, relu_d;
    logic                                        req_q, req_d;
    logic [ADDR_W-1:0]                           addr_q, addr_d;
    logic [WORD_W-1:0]                           data_q, data_d;
    logic                                        busy_q, busy_d;
    logic                                        done_q, done_d;

    // Word currently addressed by idx, before and after the ReLU clamp.
    logic [LANES-1:0][RES_W-1:0]                 lane_raw;
    logic [LANES-1:0][RES_W-1:0]                 lane_post;
    logic [ADDR_W-1:0]                           idx_ext;
    logic [ADDR_W-1:0]                           word_offset;
    logic [ADDR_W-1:0]                           word_addr;
    logic                                        last_word;
    logic                                        skip_word;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_raw[gi]  = snap_q[idx_q][gi];
            assign lane_post[gi] = (relu_q && lane_raw[gi][RES_W-1]) ? '0 : lane_raw[gi];
        end
    endgenerate

    // Address arithmetic is modulo 2^ADDR_W; overflow simply wraps.
    assign idx_ext     = ADDR_W'(idx_q);
    assign word_offset = idx_ext * stride_q;
    assign word_addr   = base_q + word_offset;
    assign last_word   = (idx_q == IDX_W'(NUM_WORDS - 1));

`ifdef WB_SKIP_ZERO_EN
    assign skip_word = (lane_post == '0);
`else
    assign skip_word = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        base_d   = base_q;
        stride_d = stride_q;
        relu_d   = relu_q;
        req_d    = req_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d   = results;
                    base_d   = base_addr;
                    stride_d = stride;
                    relu_d   = relu_en;
                    idx_d    = '0;
                    state_d  = ST_PACK;
                end
            end

            ST_PACK: begin
                if (skip_word) begin
                    // Word is dropped but still consumes its index/address slot.
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    data_d  = lane_post;
                    addr_d  = word_addr;
                    req_d   = 1'b1;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // req is always high here, so ack alone marks acceptance.
                if (mem_wr_ack) begin
                    req_d = 1'b0;
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_PACK;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            snap_q   <= '0;
            idx_q    <= '0;
            base_q   <= '0;
            stride_q <= '0;
            relu_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            relu_q   <= relu_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem_wr_req  = req_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_result_writeback.sv
// -----------------------------------------------------------------------------
// tb_result_writeback
//
// Directed, table-driven bench for result_writeback. Each table row gives the
// operation parameters plus hand-computed expectations (first/last address,
// word 0, write count, done cycle). A small packing model additionally checks
// every accepted word. Hand-written sequences cover reset state and reset
// during a pending write.
// -----------------------------------------------------------------------------
module tb_result_writeback;

    localparam int NUM_RESULTS = 32;
    localparam int RES_W       = 16;
    localparam int WORD_W      = 64;
    localparam int ADDR_W      = 10;
    localparam int NUM_WORDS   = 8;

    logic                          clk;
    logic                          rst_n;
    logic                          start;
    logic [ADDR_W-1:0]             base_addr;
    logic [ADDR_W-1:0]             stride;
    logic                          relu_en;
    logic [NUM_RESULTS*RES_W-1:0]  results;
    logic                          mem_wr_req;
    logic [ADDR_W-1:0]             mem_wr_addr;
    logic [WORD_W-1:0]             mem_wr_data;
    logic                          mem_wr_ack;
    logic                          busy;
    logic                          done;

    int tests;
    int fails;

    result_writeback #(
        .NUM_RESULTS (NUM_RESULTS),
        .RES_W       (RES_W),
        .WORD_W      (WORD_W),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .stride      (stride),
        .relu_en     (relu_en),
        .results     (results),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  base;
        logic [9:0]  stride;
        logic        relu;
        logic [15:0] r0;
        logic [15:0] r1;
        logic        zero_w2;
        logic        stall;
        logic        disturb;
        logic [9:0]  exp_first;
        logic [9:0]  exp_last;
        logic [63:0] exp_w0;
        int          exp_n;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [63:0] data;
    } wr_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Result i = i+1, with results 0/1 overridden and optionally word 2 zeroed.
    function automatic logic [511:0] fill(input vec_t v);
        logic [511:0] r;
        for (int i = 0; i < NUM_RESULTS; i++) r[i*16 +: 16] = 16'(i + 1);
        r[15:0]  = v.r0;
        r[31:16] = v.r1;
        if (v.zero_w2)
            for (int i = 8; i < 12; i++) r[i*16 +: 16] = 16'h0000;
        return r;
    endfunction

    function automatic logic [63:0] model_word(input logic [511:0] res, input int w, input logic relu);
        logic [63:0] d;
        logic [15:0] lane;
        for (int k = 0; k < 4; k++) begin
            lane = res[(w*4 + k)*16 +: 16];
            if (relu && lane[15]) lane = 16'h0000;
            d[k*16 +: 16] = lane;
        end
        return d;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [511:0] snap;
        wr_t          exp_q[$];
        wr_t          e;
        logic [63:0]  d;
        logic [9:0]   held_addr;
        logic [63:0]  held_data;
        logic [9:0]   first_addr;
        logic [9:0]   last_addr;
        logic [63:0]  w0;
        int           n, nw, done_cyc, first_cyc, stall_cnt, stable_bad, data_bad;
        logic         ack;

        snap = fill(v);
        for (int w = 0; w < NUM_WORDS; w++) begin
            d = model_word(snap, w, v.relu);
`ifdef WB_SKIP_ZERO_EN
            if (d == 64'h0) continue;
`endif
            e.addr = v.base + 10'(w) * v.stride;
            e.data = d;
            exp_q.push_back(e);
        end

        @(negedge clk);
        results    = snap;
        base_addr  = v.base;
        stride     = v.stride;
        relu_en    = v.relu;
        mem_wr_ack = 1'b1;
        start      = 1'b1;

        n = 0; nw = 0; done_cyc = -1; first_cyc = -1; stall_cnt = 0;
        stable_bad = 0; data_bad = 0;
        first_addr = '0; last_addr = '0; w0 = '0;
        held_addr = '0; held_data = '0;

        while (1) begin
            @(posedge clk);
            #1;
            n++;
            start = v.disturb && (n == 3 || n == 17);
            if (v.disturb && n == 1) results = {32{16'hAAAA}};
            if (done) done_cyc = n;

            ack = 1'b1;
            if (v.stall && mem_wr_req && nw == 3 && stall_cnt < 5) begin
                ack = 1'b0;
                if (stall_cnt == 0) begin
                    held_addr = mem_wr_addr;
                    held_data = mem_wr_data;
                end else if (mem_wr_addr !== held_addr || mem_wr_data !== held_data) begin
                    stable_bad++;
                end
                stall_cnt++;
            end
            mem_wr_ack = ack;

            if (mem_wr_req && ack) begin
                if (nw == 0) begin
                    first_cyc  = n;
                    first_addr = mem_wr_addr;
                    w0         = mem_wr_data;
                end
                if (v.stall && nw == 3 &&
                    (mem_wr_addr !== held_addr || mem_wr_data !== held_data))
                    stable_bad++;
                if (nw < exp_q.size()) begin
                    if (mem_wr_addr !== exp_q[nw].addr || mem_wr_data !== exp_q[nw].data)
                        data_bad++;
                end
                last_addr = mem_wr_addr;
                nw++;
            end

            if (!busy || n >= 100) break;
        end
        start      = 1'b0;
        mem_wr_ack = 1'b1;

        $display("[TB] %s: writes=%0d first=0x%0h last=0x%0h word0=0x%0h done_cycle=%0d",
                 v.name, nw, first_addr, last_addr, w0, done_cyc);

        check({v.name, " terminated"}, 64'(n < 100), 64'd1);
        check({v.name, " write count"}, 64'(nw), 64'(v.exp_n));
        check({v.name, " model count"}, 64'(nw), 64'(exp_q.size()));
        check({v.name, " first req cycle"}, 64'(first_cyc), 64'd2);
        check({v.name, " first addr"}, 64'(first_addr), 64'(v.exp_first));
        check({v.name, " last addr"}, 64'(last_addr), 64'(v.exp_last));
        check({v.name, " word0"}, w0, v.exp_w0);
        check({v.name, " word/addr mismatches"}, 64'(data_bad), 64'd0);
        check({v.name, " done cycle"}, 64'(done_cyc), 64'(v.exp_done));
        check({v.name, " busy drop cycle"}, 64'(n), 64'(v.exp_done + 1));
        if (v.stall) begin
            check({v.name, " stall cycles"}, 64'(stall_cnt), 64'd5);
            check({v.name, " stall stability"}, 64'(stable_bad), 64'd0);
        end
        if (v.disturb) begin
            // A queued or restarted operation would raise busy here.
            n = 0;
            repeat (4) begin
                @(posedge clk);
                #1;
                if (busy) n++;
            end
            check({v.name, " idle after ignored starts"}, 64'(n), 64'd0);
        end
    endtask

    vec_t vecs[8];
    int   seen_done;

    initial begin
        tests = 0;
        fails = 0;

        vecs[0] = '{"basic",      10'h010, 10'd1, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0,
                    10'h010, 10'h017, 64'h0004_0003_0002_0001, 8, 17};
        vecs[1] = '{"relu_on",    10'h100, 10'd2, 1'b1, 16'hFFF6, 16'h0005, 1'b0, 1'b0, 1'b0,
                    10'h100, 10'h10E, 64'h0004_0003_0005_0000, 8, 17};
        vecs[2] = '{"relu_off",   10'h200, 10'd1, 1'b0, 16'hFFF6, 16'h0005, 1'b0, 1'b0, 1'b0,
                    10'h200, 10'h207, 64'h0004_0003_0005_FFF6, 8, 17};
        vecs[3] = '{"wrap",       10'h3FE, 10'd3, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0,
                    10'h3FE, 10'h013, 64'h0004_0003_0002_0001, 8, 17};
        vecs[4] = '{"stride0",    10'h055, 10'd0, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0,
                    10'h055, 10'h055, 64'h0004_0003_0002_0001, 8, 17};
        vecs[5] = '{"stall",      10'h010, 10'd1, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0,
                    10'h010, 10'h017, 64'h0004_0003_0002_0001, 8, 22};
        vecs[6] = '{"disturb",    10'h030, 10'd1, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1,
                    10'h030, 10'h037, 64'h0004_0003_0002_0001, 8, 17};
`ifdef WB_SKIP_ZERO_EN
        vecs[7] = '{"zero_word2", 10'h040, 10'd1, 1'b0, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0,
                    10'h040, 10'h047, 64'h0004_0003_0002_0001, 7, 16};
`else
        vecs[7] = '{"zero_word2", 10'h040, 10'd1, 1'b0, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0,
                    10'h040, 10'h047, 64'h0004_0003_0002_0001, 8, 17};
`endif

        // Reset state
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        stride     = '0;
        relu_en    = 1'b0;
        results    = '0;
        mem_wr_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req",  64'(mem_wr_req),  64'd0);
        check("reset addr", 64'(mem_wr_addr), 64'd0);
        check("reset data", mem_wr_data,      64'd0);
        check("reset busy", 64'(busy),        64'd0);
        check("reset done", 64'(done),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while a write request is pending.
        @(negedge clk);
        results    = fill(vecs[0]);
        base_addr  = 10'h020;
        stride     = 10'd1;
        relu_en    = 1'b0;
        mem_wr_ack = 1'b1;
        start      = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("pre-reset req", 64'(mem_wr_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset req",  64'(mem_wr_req),  64'd0);
        check("async reset busy", 64'(busy),        64'd0);
        check("async reset addr", 64'(mem_wr_addr), 64'd0);
        check("async reset data", mem_wr_data,      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy || mem_wr_req) seen_done++;
        end
        $display("[TB] reset_mid_write: activity_after_reset=%0d", seen_done);
        check("no done/activity after reset", 64'(seen_done), 64'd0);

        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Write-back engine for the NPU datapath. It snapshots the 32 PE accumulator results, applies an optional ReLU, packs four 16-bit results into each 64-bit word, and writes the words to the memory array through a req/ack write port.
- It is the write-side counterpart of the arbiter's read/fetch path. main_control triggers it at the end of each layer.

Parameters:
- NUM_RESULTS, 32, number of accumulator results per layer; must be a multiple of LANES.
- RES_W, 16, width of one result (signed, two's complement).
- WORD_W, 64, memory word width; LANES = WORD_W/RES_W = 4.
- ADDR_W, 10, memory address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin write-back; sampled only in IDLE.
- base_addr  in  ADDR_W  address of word 0; sampled with start.
- stride  in  ADDR_W  address increment between words; sampled with start.
- relu_en  in  1  apply ReLU; sampled with start.
- results  in  NUM_RESULTS*RES_W  flattened PE results; result i occupies bits [i*RES_W+RES_W-1 : i*RES_W].
- mem_wr_req  out  1  write request.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  WORD_W  write data.
- mem_wr_ack  in  1  memory accepts the write in the cycle where req and ack are both 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last word has been accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0; word index=0; snapshot buffer=0.
- States: IDLE, PACK, WRITE, DONE.
- IDLE:
  - start=1 → snapshot all results, latch base_addr, stride and relu_en, set idx=0, go to PACK.
  - After the snapshot, the PEs may change `results` freely.
- PACK (1 cycle):
  - Build word idx. Lane k (bits [k*16+15:k*16], lane 0 at the LSBs) = snapshot[idx*LANES+k].
  - If relu_en, a negative lane (MSB=1) becomes 0; other values pass unchanged.
  - Register the word into mem_wr_data.
  - mem_wr_addr = (base_addr + idx*stride) mod 2^ADDR_W; wrap-around is silent.
  - Go to WRITE.
- WRITE:
  - mem_wr_req=1. Address and data stay stable until ack.
  - On ack with idx<NUM_RESULTS/LANES-1: req=0 next cycle, idx+1, go to PACK.
  - On ack with the last idx: req=0 next cycle, go to DONE.
  - No ack: remain in WRITE indefinitely; there is no timeout.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 during DONE.
- Timing with mem_wr_ack tied 1 and start at cycle 0:
  - PACK in cycle 1, first req in cycle 2.
  - Each word takes 2 cycles; req is high in cycles 2, 4, …, 16.
  - done=1 in cycle 17; busy=0 from cycle 18.
- Ack handling: ack while req=0 is ignored. Ack has no combinational path to req; req is registered.
- start while busy is ignored. It is neither queued nor allowed to restart.
- start in the same cycle as the DONE pulse is ignored. start in the cycle after done is accepted.
- Reset mid-operation: immediate return to the reset values. Any in-flight request is dropped, and no done is issued.
- stride=0 is legal: every word goes to base_addr and the last write wins.

Optional Feature:
- Macro WB_SKIP_ZERO_EN.
- Defined:
  - In PACK, if all four lanes of the post-ReLU word are 0, no request is issued for that word.
  - idx still advances, and the address sequence is unchanged, so the next word keeps its own address.
  - A skipped word costs 1 cycle (PACK only).
  - If the last word is skipped, go directly from PACK to DONE.
- Not defined: every word is written unconditionally, exactly as described above.

Test Plan:
- Basic write-back:
  - Stimulus: ack tied 1, base=0x010, stride=1, relu_en=0, result i = i+1.
  - Response: 8 writes to 0x010–0x017; word0=0x0004_0003_0002_0001; done in cycle 17.
- ReLU:
  - Stimulus: result0=0xFFF6 (-10), result1=0x0005, relu_en=1.
  - Response: word0 lane0=0x0000, lane1=0x0005.
  - With relu_en=0, lane0=0xFFF6.
- Back-pressure:
  - Stimulus: ack held 0 for 5 cycles on word 3.
  - Response: req, addr and data are stable for all 5 cycles; no word is lost or duplicated; done comes 5 cycles later than the no-stall case.
- Address wrap and stride:
  - Stimulus: base=0x3FE, stride=3.
  - Response: addresses 0x3FE, 0x001, 0x004, …, 0x013.
- Control corners:
  - Stimulus: start pulsed while busy; results changed right after start.
  - Response: the second start is ignored, and the written data matches the snapshot.
  - Stimulus: rst=0 asserted during WRITE.
  - Response: req drops asynchronously, there is no done, and a subsequent start runs cleanly.
- WB_SKIP_ZERO_EN:
  - Stimulus: results 8–11 all 0 (word 2), ack=1.
  - Response: 7 requests; the address sequence skips base+2*stride; done in cycle 16.
